fmul_post: RTL and testbench

- Back-end of the FP32 multiplier datapath. Sits directly downstream of the 24x24 carry-save mantissa multiplier.
- Takes that multiplier's 48-bit carry/sum pair plus the sign, pre-biased exponent and special-case flags from the front-end.
- Performs the final carry-propagate add, normalisation, round-to-nearest-even, overflow/underflow handling and IEEE-754 single packing.
- 3-stage pipeline with valid/ready handshake; result goes to the VFPU writeback mux.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_round_rne.sv | 31 +++
 rtl/fmul_post.sv | 153 +++++++++++++++
 tb/tb_fmul_post.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 constants, flag layout and packing helper for the VFPU back-ends.
package fp_pkg;

    localparam int EXP_BITS  = 8;
    localparam int FRAC_BITS = 23;
    localparam int MANT_BITS = FRAC_BITS + 1;
    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 2 * BIAS + 1;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    localparam int FLAG_INEXACT = 0;
    localparam int FLAG_UNF     = 1;
    localparam int FLAG_OVF     = 2;

    // Field order matches the FLAG_* bit positions above.
    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } fp_flags_t;

    function automatic logic [31:0] fp_pack(input logic sign,
                                            input logic [EXP_BITS-1:0] exp,
                                            input logic [FRAC_BITS-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised mantissa with guard/sticky; bumps the
// exponent when rounding carries out of the mantissa.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int E_W = 12
) (
    input  logic [MANT_BITS-1:0] m,
    input  logic                 g,
    input  logic                 s,
    input  logic signed [E_W-1:0] e,
    output logic [FRAC_BITS-1:0] frac,
    output logic signed [E_W-1:0] e_out,
    output logic                 inexact
);

    logic           inc;
    logic [MANT_BITS:0] m_r;
    logic           unused_hidden;

    assign inc     = g & (s | m[0]);
    assign m_r     = {1'b0, m} + {{MANT_BITS{1'b0}}, inc};
    assign inexact = g | s;

    // A carry out means the mantissa became 2.0: renormalise to 1.0, exponent + 1.
    assign frac    = m_r[MANT_BITS] ? '0 : m_r[FRAC_BITS-1:0];
    assign e_out   = m_r[MANT_BITS] ? e + E_W'(1) : e;

    assign unused_hidden = m_r[FRAC_BITS];

endmodule

// File: rtl/fmul_post.sv
// FP32 multiplier back-end: CPA, normalise, RNE round and pack in a 3-stage
// pipeline with a global-stall valid/ready handshake.
module fmul_post
    import fp_pkg::*;
#(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = CANON_QNAN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [47:0]             in_carry,
    input  logic [47:0]             in_sum,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic                    in_zero,
    input  logic                    in_inf,
    input  logic                    in_nan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_inexact
);

    // Two guard bits absorb the normalise and rounding increments.
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_OVF = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] E_UNF = '0;

    logic en;

    logic                    v1, v2;
    logic [47:0]             p1;
    logic signed [EXP_W-1:0] exp1;
    logic                    sign1, zero1, inf1, nan1;

    logic [MANT_BITS-1:0]    m2;
    logic                    g2, s2;
    logic signed [EW-1:0]    e2;
    logic                    sign2, zero2, inf2, nan2;

    logic signed [EW-1:0]    exp1_ext;
    logic [MANT_BITS-1:0]    m_n;
    logic                    g_n, s_n;
    logic signed [EW-1:0]    e_n;

    logic [FRAC_BITS-1:0]    frac_r;
    logic signed [EW-1:0]    e_r;
    logic                    nx_r;

    logic [31:0]             res_c;
    fp_flags_t               flags_c, flags_q;

    // NOTE: one enable for every stage; a stalled output freezes the whole pipe.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    assign exp1_ext = {{2{exp1[EXP_W-1]}}, exp1};

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        m_n = p1[46:23];
        g_n = p1[22];
        s_n = |p1[21:0];
        e_n = exp1_ext;
        if (p1[47]) begin
            m_n = p1[47:24];
            g_n = p1[23];
            s_n = |p1[22:0];
            e_n = exp1_ext + EW'(1);
        end
    end

    fp_round_rne #(.E_W(EW)) u_round (
        .m       (m2),
        .g       (g2),
        .s       (s2),
        .e       (e2),
        .frac    (frac_r),
        .e_out   (e_r),
        .inexact (nx_r)
    );

    always_comb begin
        res_c   = '0;
        flags_c = '0;
        if (nan2) begin
            res_c = QNAN;
        end else if (inf2) begin
            res_c = fp_pack(sign2, '1, '0);
        end else if (zero2) begin
            res_c = fp_pack(sign2, '0, '0);
        end else if (e_r >= E_OVF) begin
            res_c           = fp_pack(sign2, '1, '0);
            flags_c.ovf     = 1'b1;
            flags_c.inexact = 1'b1;
        end else if (e_r <= E_UNF) begin
            res_c           = fp_pack(sign2, '0, '0);
            flags_c.unf     = 1'b1;
            flags_c.inexact = 1'b1;
        end else begin
            res_c           = fp_pack(sign2, e_r[EXP_BITS-1:0], frac_r);
            flags_c.inexact = nx_r;
        end
    end

    // Control and output registers: reset clears them, dropping in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            flags_q    <= '0;
        end else if (en) begin
            // NOTE: non-blocking so each stage samples the previous stage's old value.
            v1         <= in_valid;
            v2         <= v1;
            out_valid  <= v2;
            out_result <= v2 ? res_c : '0;
            flags_q    <= v2 ? flags_c : '0;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            p1    <= in_carry + in_sum;
            exp1  <= in_exp;
            sign1 <= in_sign;
            zero1 <= in_zero;
            inf1  <= in_inf;
            nan1  <= in_nan;

            m2    <= m_n;
            g2    <= g_n;
            s2    <= s_n;
            e2    <= e_n;
            sign2 <= sign1;
            zero2 <= zero1;
            inf2  <= inf1;
            nan2  <= nan1;
        end
    end

    assign out_ovf     = flags_q.ovf;
    assign out_unf     = flags_q.unf;
    assign out_inexact = flags_q.inexact;

endmodule

// File: tb/tb_fmul_post.sv
// Directed self-checking bench for fmul_post: arithmetic vectors, specials,
// backpressure and mid-stream reset.
module tb_fmul_post;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_carry, in_sum;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic        in_zero, in_inf, in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_inexact;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [47:0] p;
        logic [9:0]  e;
        logic        sign, z, i, n;
        logic [31:0] res;
        logic [2:0]  flg;   // {ovf, unf, inexact}
    } vec_t;

    vec_t vecs[18];

    fmul_post #(.EXP_W(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_carry    (in_carry),
        .in_sum      (in_sum),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_zero     (in_zero),
        .in_inf      (in_inf),
        .in_nan      (in_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] p, input logic [9:0] e, input logic sign,
                                input logic z, input logic i, input logic n,
                                input logic [31:0] res, input logic [2:0] flg);
        vec_t v;
        v.p = p; v.e = e; v.sign = sign; v.z = z; v.i = i; v.n = n;
        v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit split);
        logic [47:0] c;
        c = split ? {$urandom, $urandom} : 48'h0;
        in_carry = c;
        in_sum   = v.p - c;
        in_exp   = v.e;
        in_sign  = v.sign;
        in_zero  = v.z;
        in_inf   = v.i;
        in_nan   = v.n;
    endtask

    // Single beat through an empty pipe; expects out_valid exactly 3 edges later.
    task automatic run_one(input string tag, input vec_t v, input bit split);
        drive(v, split);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lat2"}, {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_res"}, out_result, v.res);
        check({tag, "_flags"}, {29'h0, out_ovf, out_unf, out_inexact}, {29'h0, v.flg});
        @(posedge clk); #1;
    endtask

    task automatic stream_bp();
        int tx = 0;
        int rx = 0;
        int extra = 0;
        for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
            out_ready = (cyc >= 8);
            in_valid  = (tx < 5);
            if (tx < 5) drive(vecs[tx], 1'b1);
            @(negedge clk);
            if (cyc >= 3 && cyc < 8) begin
                check($sformatf("bp_hold_c%0d", cyc), out_result, vecs[0].res);
                check($sformatf("bp_in_ready_c%0d", cyc), {31'h0, in_ready}, 32'h0);
            end
            if (cyc == 6) begin
                check("bp_out_valid", {31'h0, out_valid}, 32'h1);
                check("bp_accepted", tx, 3);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", rx), out_result, vecs[rx].res);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_delivered", rx, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        check("bp_no_dup", extra, 0);
    endtask

    task automatic reset_mid();
        int stale = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k], 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        check("rst_mid_result", out_result, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_mid_stale", stale, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mk(48'h9000_0000_0000, 10'd127, 0, 0, 0, 0, 32'h4010_0000, 3'b000);
        vecs[1]  = mk(48'h4000_00C0_0000, 10'd127, 0, 0, 0, 0, 32'h3F80_0002, 3'b001);
        vecs[2]  = mk(48'h4000_0040_0000, 10'd127, 0, 0, 0, 0, 32'h3F80_0000, 3'b001);
        vecs[3]  = mk(48'h7FFF_FFC0_0000, 10'd127, 0, 0, 0, 0, 32'h4000_0000, 3'b001);
        vecs[4]  = mk(48'h8000_0000_0000, 10'd254, 1, 0, 0, 0, 32'hFF80_0000, 3'b101);
        vecs[5]  = mk(48'h4000_0000_0000, 10'd0,   0, 0, 0, 0, 32'h0000_0000, 3'b011);
        vecs[6]  = mk(48'h1234_5678_9ABC, 10'd127, 0, 0, 0, 1, 32'h7FC0_0000, 3'b000);
        vecs[7]  = mk(48'h1234_5678_9ABC, 10'd127, 1, 0, 1, 0, 32'hFF80_0000, 3'b000);
        vecs[8]  = mk(48'h9000_0000_0000, 10'd127, 1, 1, 0, 0, 32'h8000_0000, 3'b000);
        vecs[9]  = mk(48'h9000_0000_0000, 10'd127, 1, 0, 0, 0, 32'hC010_0000, 3'b000);
        vecs[10] = mk(48'h4000_0000_0000, 10'd254, 0, 0, 0, 0, 32'h7F00_0000, 3'b000);
        vecs[11] = mk(48'h4000_0000_0000, 10'd1,   0, 0, 0, 0, 32'h0080_0000, 3'b000);
        vecs[12] = mk(48'h7FFF_FFC0_0000, 10'd254, 0, 0, 0, 0, 32'h7F80_0000, 3'b101);
        vecs[13] = mk(48'h8000_0000_0000, 10'h3FB, 0, 0, 0, 0, 32'h0000_0000, 3'b011);
        vecs[14] = mk(48'h4000_0000_0001, 10'd127, 0, 0, 0, 0, 32'h3F80_0000, 3'b001);
        vecs[15] = mk(48'h0000_0000_0000, 10'd127, 0, 1, 1, 0, 32'h7F80_0000, 3'b000);
        vecs[16] = mk(48'h0000_0000_0000, 10'd127, 1, 0, 1, 1, 32'h7FC0_0000, 3'b000);
        vecs[17] = mk(48'h8000_0000_0000, 10'h3FF, 1, 0, 0, 0, 32'h8000_0000, 3'b011);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_result", out_result, 32'h0);
        check("rst_flags", {29'h0, out_ovf, out_unf, out_inexact}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 18; k++) run_one($sformatf("v%0d", k), vecs[k], 1'b0);
        run_one("split_1p5", vecs[0], 1'b1);
        run_one("split_rne", vecs[1], 1'b1);
        run_one("split_carry", vecs[3], 1'b1);

        stream_bp();
        reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
